// File: rtl/bp_cce_src_q_arb.sv
// rtl/bp_cce_src_q_arb.sv - CCE source queue arbiter with starvation guard for lce_req
module bp_cce_src_q_arb #(
   parameter int starve_limit_p = 15
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       stall_i,
   input  logic       mem_resp_v_i,
   input  logic       lce_resp_v_i,
   input  logic       lce_req_v_i,
   input  logic       pending_v_i,
   output logic       grant_v_o,
   output logic [1:0] grant_sel_o,
   input  logic       grant_yumi_i,
   input  logic       done_i,
   output logic       busy_o,
   output logic       starve_o
);

   localparam int cnt_width_lp = (starve_limit_p + 1 <= 2) ? 1 : $clog2(starve_limit_p + 1);
   localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

   // queue encodings on grant_sel_o
   localparam logic [1:0] sel_lce_req  = 2'd0;
   localparam logic [1:0] sel_lce_resp = 2'd1;
   localparam logic [1:0] sel_mem_resp = 2'd2;
   localparam logic [1:0] sel_pending  = 2'd3;

   typedef enum logic [1:0] {
      st_idle,
      st_offer,
      st_busy
   } state_e;

   state_e                  state;
   logic                    rr_pending;   // 1: pending wins an lce_req/pending tie
   logic [cnt_width_lp-1:0] starve_cnt;
   logic [cnt_width_lp-1:0] cnt_inc;
   logic [1:0]              winner;
   logic                    any_v;
   logic                    sel_v;

   // winner selection from current valids, starvation flag and round-robin pointer
   always_comb begin
      any_v   = mem_resp_v_i | lce_resp_v_i | lce_req_v_i | pending_v_i;
      cnt_inc = (starve_cnt == limit_lp) ? starve_cnt : starve_cnt + cnt_width_lp'(1);
      winner  = sel_lce_req;
      if (starve_o && lce_req_v_i) begin
         winner = sel_lce_req;
      end else if (mem_resp_v_i) begin
         winner = sel_mem_resp;
      end else if (lce_resp_v_i) begin
         winner = sel_lce_resp;
      end else if (lce_req_v_i && pending_v_i) begin
         winner = rr_pending ? sel_pending : sel_lce_req;
      end else if (pending_v_i) begin
         winner = sel_pending;
      end
      case (grant_sel_o)
         sel_lce_req:  sel_v = lce_req_v_i;
         sel_lce_resp: sel_v = lce_resp_v_i;
         sel_mem_resp: sel_v = mem_resp_v_i;
         default:      sel_v = pending_v_i;
      endcase
   end

   // arbitration FSM with registered outputs; stall freezes everything
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state       <= st_idle;
         grant_v_o   <= 1'b0;
         grant_sel_o <= sel_lce_req;
         busy_o      <= 1'b0;
         starve_o    <= 1'b0;
         starve_cnt  <= '0;
         rr_pending  <= 1'b0;
      end else if (!stall_i) begin
         case (state)
            st_idle: begin
               if (any_v) begin
                  state       <= st_offer;
                  grant_v_o   <= 1'b1;
                  grant_sel_o <= winner;
                  if (lce_req_v_i && (winner != sel_lce_req)) begin
                     starve_cnt <= cnt_inc;
                     starve_o   <= (cnt_inc == limit_lp);
                  end
               end
            end
            st_offer: begin
               if (grant_yumi_i) begin
                  if (grant_sel_o == sel_lce_req) begin
                     starve_cnt <= '0;
                     starve_o   <= 1'b0;
                     rr_pending <= 1'b1;
                  end else if (grant_sel_o == sel_pending) begin
                     rr_pending <= 1'b0;
                  end
                  grant_v_o <= 1'b0;
                  if (done_i) begin
                     state <= st_idle;
                  end else begin
                     state  <= st_busy;
                     busy_o <= 1'b1;
                  end
               end else if (!sel_v) begin
                  // offered head vanished: withdraw without touching pointer or counter
                  state     <= st_idle;
                  grant_v_o <= 1'b0;
               end
            end
            st_busy: begin
               if (done_i) begin
                  state  <= st_idle;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state     <= st_idle;
               grant_v_o <= 1'b0;
               busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule
